i2s_codec_model: RTL and testbench

- Synthesizable model of the slave (CODEC) end of the 16-bit audio serial link.
- Consumes the master-generated LRCLK, SCLK, MCLK and RSTn and the serial stream on SDin; drives SDout back to the master.
- Presents received samples and accepts transmit samples in parallel form.
- Used in loopback/bench and FPGA self-test builds in place of the physical CODEC.

---
 rtl/i2s_codec_model.sv | 141 ++++++++++++++
 tb/tb_i2s_codec_model.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_codec_model.sv
// rtl/i2s_codec_model.sv - slave (CODEC) end of a 16-bit left-justified audio serial link
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   LRCLK, SCLK       word select (1 = left) and bit clock from the master
//   MCLK              master clock, monitored only
//   RSTn              CODEC reset from the master, active low
//   SDin / SDout      serial data from / to the master, MSB first
//   tx_lft, tx_rht    words to send, captured on frame_start
//   frame_start       1-clk pulse when the tx words are captured
//   rx_lft, rx_rht    last complete received words
//   rx_valid          1-clk pulse when rx_lft/rx_rht form a new pair
//   frame_err         sticky: a half-frame did not carry DATA_W bits
`timescale 1ns/1ps
module i2s_codec_model #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LRCLK,
    input  logic              SCLK,
    input  logic              MCLK,
    input  logic              RSTn,
    input  logic              SDin,
    output logic              SDout,
    input  logic [DATA_W-1:0] tx_lft,
    input  logic [DATA_W-1:0] tx_rht,
    output logic              frame_start,
    output logic [DATA_W-1:0] rx_lft,
    output logic [DATA_W-1:0] rx_rht,
    output logic              rx_valid,
    output logic              frame_err
);
    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    // Bits [SYNC_STAGES-1:0] synchronize, bit [SYNC_STAGES] is the history flop.
    logic [SYNC_STAGES:0] lr_sync, sck_sync, sd_sync, rn_sync;

    logic              armed;
    logic              lft_bad;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rht_hold;

    logic lr_s, lr_h, sck_s, sck_h, sd_s, run;
    logic lr_rise, lr_fall, lr_edge, sck_rise, sck_fall, cnt_ok;

    logic unused_mclk;
    assign unused_mclk = MCLK;

    assign lr_s     = lr_sync[SYNC_STAGES-1];
    assign lr_h     = lr_sync[SYNC_STAGES];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign sck_h    = sck_sync[SYNC_STAGES];
    assign sd_s     = sd_sync[SYNC_STAGES-1];
    assign lr_rise  = lr_s & ~lr_h;
    assign lr_fall  = ~lr_s & lr_h;
    assign lr_edge  = lr_rise | lr_fall;
    assign sck_rise = sck_s & ~sck_h;
    assign sck_fall = ~sck_s & sck_h;
    assign cnt_ok   = (bit_cnt == CNT_FULL);

    // The RSTn rise cycle is still treated as held: after rst the pin
    // synchronizers restart from 0, so a high LRCLK/SCLK pin shows a false
    // rise on exactly that cycle and must not arm the block.
    assign run = rn_sync[SYNC_STAGES-1] & rn_sync[SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lr_sync     <= '0;
            sck_sync    <= '0;
            sd_sync     <= '0;
            rn_sync     <= '0;
            armed       <= 1'b0;
            lft_bad     <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rht_hold    <= '0;
            SDout       <= 1'b0;
            frame_start <= 1'b0;
            rx_lft      <= '0;
            rx_rht      <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            lr_sync     <= {lr_sync[SYNC_STAGES-1:0], LRCLK};
            sck_sync    <= {sck_sync[SYNC_STAGES-1:0], SCLK};
            sd_sync     <= {sd_sync[SYNC_STAGES-1:0], SDin};
            rn_sync     <= {rn_sync[SYNC_STAGES-1:0], RSTn};
            rx_valid    <= 1'b0;
            frame_start <= 1'b0;
            if (!run) begin
                armed    <= 1'b0;
                lft_bad  <= 1'b0;
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
                rht_hold <= '0;
                SDout    <= 1'b0;
            end else begin
                SDout <= tx_shift[DATA_W-1];
                if (lr_edge) begin
                    armed    <= 1'b1;
                    bit_cnt  <= '0;
                    rx_shift <= '0;
                    if (armed && !cnt_ok)
                        frame_err <= 1'b1;
                    if (lr_fall) begin
                        // Remember a bad left half so the pair is not reported.
                        lft_bad  <= armed && !cnt_ok;
                        if (armed && cnt_ok)
                            rx_lft <= rx_shift;
                        tx_shift <= rht_hold;
                    end else begin
                        lft_bad <= 1'b0;
                        if (armed && cnt_ok) begin
                            rx_rht   <= rx_shift;
                            rx_valid <= ~lft_bad;
                        end
                        frame_start <= 1'b1;
                        tx_shift    <= tx_lft;
                        rht_hold    <= tx_rht;
                    end
                end else begin
                    // Count saturates one past DATA_W so an over-long half is visible.
                    if (sck_rise && bit_cnt <= CNT_FULL) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (!cnt_ok)
                            rx_shift <= {rx_shift[DATA_W-2:0], sd_s};
                    end
                    if (sck_fall)
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_codec_model.sv
// tb/tb_i2s_codec_model.sv - self-checking bench for i2s_codec_model
`timescale 1ns/1ps
module tb_i2s_codec_model;
    logic        clk = 1'b0, rst = 1'b1;
    logic        LRCLK = 1'b0, SCLK = 1'b0, MCLK = 1'b0, RSTn = 1'b1, SDin = 1'b0;
    logic        SDout, frame_start, rx_valid, frame_err;
    logic [15:0] tx_lft = 16'h8001, tx_rht = 16'h7FFE;
    logic [15:0] rx_lft, rx_rht;

    typedef struct { logic [15:0] l; logic [15:0] r; } pair_t;
    pair_t exp_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, lr_rise_cyc = 0;
    logic [15:0] last_l = 16'h0, last_r = 16'h0;

    i2s_codec_model #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .LRCLK(LRCLK), .SCLK(SCLK), .MCLK(MCLK), .RSTn(RSTn),
        .SDin(SDin), .SDout(SDout), .tx_lft(tx_lft), .tx_rht(tx_rht),
        .frame_start(frame_start), .rx_lft(rx_lft), .rx_rht(rx_rht),
        .rx_valid(rx_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always #3 MCLK = ~MCLK;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Scoreboard: each rx_valid pops one expected pair.
    always @(negedge clk) begin
        if (!rst && rx_valid) begin
            pair_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rx_valid_unexpected cycle=%0d rx_lft=%h rx_rht=%h", cyc, rx_lft, rx_rht);
            end else begin
                e = exp_q.pop_front();
                if ({rx_lft, rx_rht} !== {e.l, e.r}) begin
                    failures++;
                    $display("FAIL rx_pair got=%h_%h exp=%h_%h", rx_lft, rx_rht, e.l, e.r);
                end
                checks++;
                if (cyc - lr_rise_cyc !== 3) begin
                    failures++;
                    $display("FAIL rx_valid_latency got=%0d exp=3", cyc - lr_rise_cyc);
                end
            end
        end
    end

    // One SCLK period: low 16 clk (data changes), high 16 clk (master samples SDout on the rise).
    task automatic drive_bit(input logic lr, input logic b, output logic q);
        @(negedge clk);
        if (lr && !LRCLK) lr_rise_cyc = cyc;
        LRCLK = lr;
        SCLK  = 1'b0;
        SDin  = b;
        repeat (16) @(negedge clk);
        SCLK = 1'b1;
        q    = SDout;
        repeat (15) @(negedge clk);
    endtask

    task automatic send_half(input logic lr, input logic [15:0] w, input int nbits, output logic [15:0] cap);
        logic q;
        cap = 16'h0;
        for (int i = 0; i < nbits; i++) begin
            drive_bit(lr, (i < 16) ? w[15-i] : 1'b0, q);
            if (i < 16) cap[15-i] = q;
        end
    endtask

    task automatic close_frame();
        @(negedge clk);
        if (!LRCLK) lr_rise_cyc = cyc;
        LRCLK = 1'b1;
        SCLK  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit expect_valid,
                              output logic [15:0] cl, output logic [15:0] cr);
        pair_t p;
        send_half(1'b1, l, 16, cl);
        send_half(1'b0, r, 16, cr);
        if (expect_valid) begin
            p.l = l; p.r = r;
            exp_q.push_back(p);
            last_l = l; last_r = r;
        end
        close_frame();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            LRCLK = 1'($urandom); SCLK = 1'($urandom); SDin = 1'($urandom); RSTn = 1'($urandom);
            checks++;
            if ({SDout, rx_valid, frame_start, frame_err, rx_lft, rx_rht} !== 36'h0) begin
                failures++;
                $display("FAIL reset_outputs got=%h exp=0", {SDout, rx_valid, frame_start, frame_err, rx_lft, rx_rht});
            end
        end
        LRCLK = 1'b0; SCLK = 1'b0; SDin = 1'b0; RSTn = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({SDout, frame_err} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release got=%b exp=00", {SDout, frame_err});
        end
    endtask

    task automatic test_receive();
        logic [15:0] cl, cr;
        send_frame(16'hA5C3, 16'h1234, 1'b1, cl, cr);
    endtask

    task automatic test_transmit();
        logic [15:0] cl, cr;
        send_frame(16'h0F0F, 16'hF0F0, 1'b1, cl, cr);
        checks++;
        if (cl[15] !== 1'b1) begin
            failures++;
            $display("FAIL tx_first_bit got=%b exp=1", cl[15]);
        end
        checks++;
        if ({cl, cr} !== {16'h8001, 16'h7FFE}) begin
            failures++;
            $display("FAIL tx_words got=%h_%h exp=8001_7ffe", cl, cr);
        end
        tx_lft = 16'h3C5A; tx_rht = 16'hC3A5;
        send_frame(16'h1111, 16'h2222, 1'b1, cl, cr);
        send_frame(16'h3333, 16'h4444, 1'b1, cl, cr);
        checks++;
        if ({cl, cr} !== {16'h3C5A, 16'hC3A5}) begin
            failures++;
            $display("FAIL tx_words_2 got=%h_%h exp=3c5a_c3a5", cl, cr);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] cl, cr, l, r;
        for (int k = 0; k < 3; k++) begin
            l = 16'($urandom); r = 16'($urandom);
            send_frame(l, r, 1'b1, cl, cr);
        end
    endtask

    task automatic test_mid_frame_start();
        logic [15:0] w, cr;
        logic q;
        pair_t p;
        w = 16'hBEEF;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) rst = 1'b0;
            drive_bit(1'b1, w[15-i], q);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_start_err_left got=%b exp=0", frame_err);
        end
        send_half(1'b0, 16'h6A6A, 16, cr);
        p.l = 16'h0000; p.r = 16'h6A6A;
        exp_q.push_back(p);
        last_l = p.l; last_r = p.r;
        close_frame();
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_start_err got=%b exp=0", frame_err);
        end
    endtask

    task automatic test_bad_framing();
        logic [15:0] cl, cr;
        send_half(1'b1, 16'hFFFF, 17, cl);
        send_half(1'b0, 16'h5555, 16, cr);
        close_frame();
        checks++;
        if (frame_err !== 1'b1) begin
            failures++;
            $display("FAIL bad_frame_err got=%b exp=1", frame_err);
        end
        send_frame(16'hC001, 16'h0FF0, 1'b1, cl, cr);
        checks++;
        if (frame_err !== 1'b1) begin
            failures++;
            $display("FAIL bad_frame_sticky got=%b exp=1", frame_err);
        end
    endtask

    task automatic test_rstn_mid();
        logic [15:0] cl, cr;
        int bad;
        bad = 0;
        send_half(1'b1, 16'h9A9A, 16, cl);
        fork
            send_half(1'b0, 16'h7777, 16, cr);
            begin
                repeat (100) @(negedge clk);
                RSTn = 1'b0;
                repeat (5) @(negedge clk);
                for (int i = 0; i < 197; i++) begin
                    if (SDout !== 1'b0 || rx_valid !== 1'b0 || frame_start !== 1'b0) bad++;
                    if (i == 194) RSTn = 1'b1;
                    @(negedge clk);
                end
            end
        join
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL rstn_quiet violations=%0d exp=0", bad);
        end
        checks++;
        if ({rx_lft, rx_rht} !== {16'h9A9A, last_r}) begin
            failures++;
            $display("FAIL rstn_rx_hold got=%h_%h exp=%h_%h", rx_lft, rx_rht, 16'h9A9A, last_r);
        end
        close_frame();
        send_frame(16'h2468, 16'hACE0, 1'b1, cl, cr);
    endtask

    initial begin
        test_reset();
        test_receive();
        test_transmit();
        test_back_to_back();
        test_mid_frame_start();
        test_bad_framing();
        test_rstn_mid();
        repeat (20) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL missing_rx_valid pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
